// File: rtl/pdp8_bin_loader_pkg.sv
// pdp8_bin_loader_pkg: FSM state encoding and tape byte constants shared by the BIN loader files.
package pdp8_bin_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HI,
        S_LO,
        S_WR,
        S_END
    } state_t;

    localparam logic [1:0] FC_DATA   = 2'b00;
    localparam logic [1:0] FC_ORIGIN = 2'b01;
    localparam logic [1:0] FC_LEADER = 2'b10;
    localparam logic [1:0] FC_FIELD  = 2'b11;

    localparam logic [7:0] RUBOUT_CODE = 8'o377;

endpackage

// File: rtl/pdp8_bin_loader_frame_decode.sv
// pdp8_bin_loader_frame_decode: classifies one BIN tape byte and extracts its field/payload bits.
// Define BIN_RUBOUT_EN to recognise 377 as a rubout instead of a field-7 frame.
module pdp8_bin_loader_frame_decode
    import pdp8_bin_loader_pkg::*;
#(
    parameter logic [7:0] LEADER_CODE = 8'o200
) (
    input  logic [7:0] i_byte,
    output logic       o_is_leader,
    output logic       o_is_origin,
    output logic       o_is_data,
    output logic       o_is_field,
    output logic       o_is_rubout,
    output logic [2:0] o_field,
    output logic [5:0] o_payload
);

    logic [1:0] w_class;

    assign w_class     = i_byte[7:6];
    assign o_is_leader = (w_class == FC_LEADER) && (i_byte == LEADER_CODE);
    assign o_is_origin = (w_class == FC_ORIGIN);
    assign o_is_data   = (w_class == FC_DATA);
    assign o_is_field  = (w_class == FC_FIELD);
    assign o_field     = i_byte[5:3];
    assign o_payload   = i_byte[5:0];
`ifdef BIN_RUBOUT_EN
    assign o_is_rubout = (i_byte == RUBOUT_CODE);
`else
    assign o_is_rubout = 1'b0;
`endif

endmodule

// File: rtl/pdp8_bin_loader.sv
// pdp8_bin_loader: BIN paper-tape loader that deposits 12-bit words onto the RAM bus while the CPU is held.
// Rubout skipping (BIN_RUBOUT_EN) is decided by the frame decoder; this file handles it generically.
module pdp8_bin_loader
    import pdp8_bin_loader_pkg::*;
#(
    parameter logic [7:0] LEADER_CODE   = 8'o200,
    parameter logic [2:0] DEFAULT_FIELD = 3'o0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic [14:0] o_ram_addr,
    output logic [11:0] o_ram_data_out,
    output logic        o_ram_wr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cksum_err
);

    state_t      r_state, w_state_nxt;
    logic        w_leader, w_origin, w_data, w_field_frm, w_rubout;
    logic [2:0]  w_field;
    logic [5:0]  w_payload;
    logic        w_take, w_live;
    logic [11:0] w_word;

    logic [2:0]  r_field;
    logic [11:0] r_addr, r_sum, r_sum_pre, r_sum_excl, r_pend, r_wr_data;
    logic [14:0] r_pend_addr, r_wr_addr;
    logic [5:0]  r_hi;
    logic        r_hi_data, r_pend_v, r_ign, r_done, r_cksum_err;

    pdp8_bin_loader_frame_decode #(
        .LEADER_CODE (LEADER_CODE)
    ) u_decode (
        .i_byte      (i_byte_data),
        .o_is_leader (w_leader),
        .o_is_origin (w_origin),
        .o_is_data   (w_data),
        .o_is_field  (w_field_frm),
        .o_is_rubout (w_rubout),
        .o_field     (w_field),
        .o_payload   (w_payload)
    );

    assign w_take         = i_byte_valid & o_byte_ready;
    assign w_live         = w_take & ~w_rubout & ~r_ign;
    assign w_word         = {r_hi, w_payload};
    assign o_ram_addr     = r_wr_addr;
    assign o_ram_data_out = r_wr_data;
    assign o_done         = r_done;
    assign o_cksum_err    = r_cksum_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_byte_ready = 1'b0;
        o_busy       = 1'b1;
        o_ram_wr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start)
                    w_state_nxt = S_LEAD;
            end
            S_LEAD: begin
                o_byte_ready = 1'b1;
                if (w_live && (w_origin || w_data))
                    w_state_nxt = S_LO;
                else if (w_live && w_field_frm)
                    w_state_nxt = S_HI;
            end
            S_HI: begin
                o_byte_ready = 1'b1;
                if (w_live && (w_origin || w_data))
                    w_state_nxt = S_LO;
                else if (w_live && w_leader)
                    w_state_nxt = S_END;
            end
            S_LO: begin
                o_byte_ready = 1'b1;
                if (w_live)
                    w_state_nxt = (r_hi_data && r_pend_v) ? S_WR : S_HI;
            end
            S_WR: begin
                o_ram_wr    = 1'b1;
                w_state_nxt = S_HI;
            end
            S_END: begin
                o_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_field     <= DEFAULT_FIELD;
            r_addr      <= '0;
            r_sum       <= '0;
            r_sum_pre   <= '0;
            r_sum_excl  <= '0;
            r_pend      <= '0;
            r_pend_addr <= '0;
            r_pend_v    <= 1'b0;
            r_hi        <= '0;
            r_hi_data   <= 1'b0;
            r_ign       <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_cksum_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_sum       <= '0;
                r_sum_excl  <= '0;
                r_pend_v    <= 1'b0;
                r_ign       <= 1'b0;
                r_done      <= 1'b0;
                r_cksum_err <= 1'b0;
            end
            if (w_take && w_rubout)
                r_ign <= ~r_ign;
            if (w_live && (r_state == S_LEAD || r_state == S_HI)) begin
                if (w_field_frm)
                    r_field <= w_field;
                if (w_origin || w_data) begin
                    r_hi      <= w_payload;
                    r_hi_data <= w_data;
                    r_sum_pre <= r_sum;
                    r_sum     <= r_sum + 12'(i_byte_data);
                end
            end
            // The newest data word is held back: it may turn out to be the checksum.
            if (w_live && r_state == S_LO) begin
                r_sum <= r_sum + 12'(i_byte_data);
                if (!r_hi_data)
                    r_addr <= w_word;
                else begin
                    if (r_pend_v) begin
                        r_wr_addr <= r_pend_addr;
                        r_wr_data <= r_pend;
                    end
                    r_pend      <= w_word;
                    r_pend_addr <= {r_field, r_addr};
                    r_pend_v    <= 1'b1;
                    r_sum_excl  <= r_sum_pre;
                    r_addr      <= r_addr + 12'd1;
                end
            end
            if (r_state == S_END) begin
                r_done      <= 1'b1;
                r_cksum_err <= r_pend_v && (r_pend != r_sum_excl);
            end
        end
    end

endmodule
